// File: rtl/div_controller.sv
// Sequencing FSM for the 10-bit restoring fixed-point divider datapath.
// Drives every datapath load/select/counter control and reports busy, done and sticky errors.
module div_controller #(
    parameter logic [4:0] WDOG_MAX = 5'd20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dvz,
    input  logic       ovf,
    input  logic       co_counter,
    input  logic       be,
    output logic       sclr,
    output logic       ld_counter,
    output logic       increace_counter,
    output logic       ld_B,
    output logic       ld_Q,
    output logic       ld_ACC,
    output logic [1:0] select_Q,
    output logic [1:0] select_ACC,
    output logic       busy,
    output logic       done,
    output logic       err_dvz,
    output logic       err_ovf
);

    localparam logic [1:0] SEL_ZERO  = 2'b00;
    localparam logic [1:0] SEL_LOAD  = 2'b01;
    localparam logic [1:0] SEL_SUB   = 2'b10;
    localparam logic [1:0] SEL_SHIFT = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t     state, state_nxt;
    logic [4:0] wdog_cnt, wdog_cnt_nxt;
    logic       err_dvz_nxt, err_ovf_nxt;
    logic [1:0] sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wdog_cnt <= '0;
            err_dvz  <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wdog_cnt <= wdog_cnt_nxt;
            err_dvz  <= err_dvz_nxt;
            err_ovf  <= err_ovf_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        wdog_cnt_nxt     = wdog_cnt;
        err_dvz_nxt      = err_dvz;
        err_ovf_nxt      = err_ovf;
        sclr             = 1'b0;
        ld_counter       = 1'b0;
        increace_counter = 1'b0;
        ld_B             = 1'b0;
        ld_Q             = 1'b0;
        ld_ACC           = 1'b0;
        sel              = SEL_ZERO;
        busy             = 1'b0;
        done             = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    sclr        = 1'b1;
                    err_dvz_nxt = dvz;
                    err_ovf_nxt = 1'b0;
                    state_nxt   = dvz ? DONE : LOAD;
                end
            end
            LOAD: begin
                ld_B         = 1'b1;
                ld_Q         = 1'b1;
                ld_ACC       = 1'b1;
                ld_counter   = 1'b1;
                sel          = SEL_LOAD;
                busy         = 1'b1;
                wdog_cnt_nxt = '0;
                state_nxt    = CALC;
            end
            CALC: begin
                busy         = 1'b1;
                wdog_cnt_nxt = wdog_cnt + 5'd1;
                // An abort suppresses the iteration's register update entirely.
                if (ovf || (wdog_cnt == WDOG_MAX && !co_counter)) begin
                    err_ovf_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    ld_Q             = 1'b1;
                    ld_ACC           = 1'b1;
                    increace_counter = 1'b1;
                    sel              = be ? SEL_SUB : SEL_SHIFT;
                    if (co_counter) state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign select_Q   = sel;
    assign select_ACC = sel;

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench for div_controller: vector table, directed corner sequences,
// and randomized traffic against a cycle-indexed behavioural model.
module tb_div_controller;

    localparam logic [4:0] WDOG = 5'd20;
    localparam int SCLR = 13, LDC = 12, INC = 11, LDB = 10, LDQ = 9, LDA = 8;
    localparam int BUSY = 3, DONE = 2, EDVZ = 1, EOVF = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, dvz = 1'b0, ovf = 1'b0, co_counter = 1'b0, be = 1'b0;
    logic sclr, ld_counter, increace_counter, ld_B, ld_Q, ld_ACC, busy, done, err_dvz, err_ovf;
    logic [1:0] select_Q, select_ACC;
    logic [13:0] outs, smp;

    int n_tests = 0;
    int n_fail  = 0;

    div_controller #(.WDOG_MAX(WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dvz(dvz), .ovf(ovf),
        .co_counter(co_counter), .be(be), .sclr(sclr), .ld_counter(ld_counter),
        .increace_counter(increace_counter), .ld_B(ld_B), .ld_Q(ld_Q), .ld_ACC(ld_ACC),
        .select_Q(select_Q), .select_ACC(select_ACC), .busy(busy), .done(done),
        .err_dvz(err_dvz), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    assign outs = {sclr, ld_counter, increace_counter, ld_B, ld_Q, ld_ACC,
                   select_Q, select_ACC, busy, done, err_dvz, err_ovf};

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Model: the operation is tracked as "cycles since the accepted start".
    // m_t = 0 idle, 1 the load cycle, >=2 iteration number m_t-2; m_done marks the done cycle.
    int m_t;
    bit m_done, m_edvz, m_eovf;

    function automatic logic [13:0] pack(input bit s, input bit lc, input bit in, input bit lb,
                                         input bit lq, input bit la, input logic [1:0] sl,
                                         input bit bz, input bit dn, input bit ed, input bit eo);
        return {s, lc, in, lb, lq, la, sl, sl, bz, dn, ed, eo};
    endfunction

    function automatic logic [13:0] model_out();
        int n;
        if (m_done) return pack(0, 0, 0, 0, 0, 0, 2'd0, 0, 1, m_edvz, m_eovf);
        if (m_t == 0) return pack(start, 0, 0, 0, 0, 0, 2'd0, 0, 0, m_edvz, m_eovf);
        if (m_t == 1) return pack(0, 1, 0, 1, 1, 1, 2'd1, 1, 0, m_edvz, m_eovf);
        n = m_t - 2;
        if (ovf || (n == int'(WDOG) && !co_counter))
            return pack(0, 0, 0, 0, 0, 0, 2'd0, 1, 0, m_edvz, m_eovf);
        return pack(0, 0, 1, 0, 1, 1, be ? 2'd2 : 2'd3, 1, 0, m_edvz, m_eovf);
    endfunction

    task automatic model_step();
        if (m_done) begin
            m_done = 0; m_t = 0;
        end else if (m_t == 0) begin
            if (start) begin
                m_edvz = dvz; m_eovf = 0;
                if (dvz) m_done = 1; else m_t = 1;
            end
        end else if (m_t == 1) begin
            m_t = 2;
        end else if (ovf || (m_t - 2 == int'(WDOG) && !co_counter)) begin
            m_eovf = 1; m_done = 1; m_t = 0;
        end else if (co_counter) begin
            m_done = 1; m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_done = 0; m_edvz = 0; m_eovf = 0;
    endtask

    task automatic do_reset();
        {start, dvz, ovf, co_counter, be} = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outputs", outs, 14'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: apply inputs, check against the model mid-cycle, advance the model.
    task automatic cyc(input string tag, input logic s, input logic dz, input logic ov,
                       input logic co, input logic b);
        start = s; dvz = dz; ovf = ov; co_counter = co; be = b;
        @(negedge clk);
        smp = outs;
        chk(tag, smp, model_out());
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic start, dvz, ovf, co, be;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input bit s, input bit dz, input bit ov, input bit co, input bit b,
                                input logic [13:0] e);
        vec_t v;
        v.start = s; v.dvz = dz; v.ovf = ov; v.co = co; v.be = b; v.exp = e;
        return v;
    endfunction

    initial begin
        bit any_ld;
        model_reset();

        tbl[0]  = mk(1, 0, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl[1]  = mk(0, 0, 0, 0, 0, pack(0, 1, 0, 1, 1, 1, 2'd1, 1, 0, 0, 0));
        tbl[2]  = mk(0, 0, 0, 0, 1, pack(0, 0, 1, 0, 1, 1, 2'd2, 1, 0, 0, 0));
        tbl[3]  = mk(0, 0, 0, 0, 0, pack(0, 0, 1, 0, 1, 1, 2'd3, 1, 0, 0, 0));
        tbl[4]  = mk(1, 0, 0, 1, 1, pack(0, 0, 1, 0, 1, 1, 2'd2, 1, 0, 0, 0));
        tbl[5]  = mk(1, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0));
        tbl[6]  = mk(0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl[7]  = mk(1, 1, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl[8]  = mk(0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 0));
        tbl[9]  = mk(0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0));
        tbl[10] = mk(1, 0, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0));
        tbl[11] = mk(0, 0, 0, 0, 0, pack(0, 1, 0, 1, 1, 1, 2'd1, 1, 0, 0, 0));
        tbl[12] = mk(0, 0, 1, 1, 1, pack(0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0));
        tbl[13] = mk(0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 1));
        tbl[14] = mk(0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            start = tbl[i].start; dvz = tbl[i].dvz; ovf = tbl[i].ovf;
            co_counter = tbl[i].co; be = tbl[i].be;
            @(negedge clk);
            chk($sformatf("table[%0d]", i), outs, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // Divide-by-zero, then asynchronous reset must clear the sticky flag.
        do_reset();
        any_ld = 0;
        for (int c = 0; c <= 10; c++) begin
            cyc("dvz_seq", c == 0, c == 0, 0, 0, 0);
            any_ld |= smp[LDB] | smp[LDQ] | smp[LDA];
            if (c == 1) chk("dvz_done_c1", {smp[DONE], smp[EDVZ]}, 2'b11);
            if (c == 10) chk("dvz_sticky_c10", smp[EDVZ], 1'b1);
        end
        chk("dvz_no_load", any_ld, 1'b0);
        rst_n = 1'b0;
        #1 chk("async_reset_clears_err", outs, 14'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Nominal run after a dvz error, with ignored starts at 5 and 17, then a restart at 19.
        cyc("pre_dvz", 1, 1, 0, 0, 0);
        cyc("pre_dvz", 0, 0, 0, 0, 0);
        cyc("pre_dvz", 0, 0, 0, 0, 0);
        for (int c = 0; c <= 36; c++) begin
            cyc("nominal", c == 0 || c == 5 || c == 17 || c == 19, 0, 0,
                c == 16 || c == 35, c[0] == 1'b0);
            if (c == 0) chk("nom_sclr_c0", {smp[SCLR], smp[EDVZ]}, 2'b11);
            if (c == 1) chk("nom_load_c1", smp, pack(0, 1, 0, 1, 1, 1, 2'd1, 1, 0, 0, 0));
            if (c == 16) chk("nom_last_iter_c16", smp, pack(0, 0, 1, 0, 1, 1, 2'd2, 1, 0, 0, 0));
            if (c == 17) chk("nom_done_c17", smp, pack(0, 0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0));
            if (c == 18) chk("nom_idle_c18", smp, 14'd0);
            if (c == 19) chk("restart_sclr_c19", smp[SCLR], 1'b1);
            if (c == 36) chk("restart_done_c36", smp[DONE], 1'b1);
        end

        // Overflow at cycle 12 suppresses the update and ends the operation.
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            cyc("ovf_seq", c == 0, 0, c == 12, 0, 1);
            if (c == 12) chk("ovf_no_load_c12", {smp[LDQ], smp[LDA], smp[INC]}, 3'b000);
            if (c == 13) chk("ovf_done_c13", {smp[DONE], smp[EDVZ], smp[EOVF]}, 3'b101);
        end

        // Watchdog: co_counter never arrives.
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            cyc("wdog_seq", c == 0, 0, 0, 0, c[1]);
            if (c == 21) chk("wdog_last_load_c21", smp[LDQ], 1'b1);
            if (c == 22) chk("wdog_abort_c22", {smp[LDQ], smp[BUSY]}, 2'b01);
            if (c == 23) chk("wdog_done_c23", {smp[DONE], smp[EOVF]}, 2'b11);
        end

        // Reset asserted mid-iteration.
        do_reset();
        for (int c = 0; c < 8; c++) cyc("midreset_seq", c == 0, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1 chk("midcalc_reset_immediate", outs, 14'd0);
        @(posedge clk);
        #1 chk("midcalc_reset_edge", outs, 14'd0);
        rst_n = 1'b1;
        model_reset();
        cyc("post_reset_idle", 0, 0, 0, 0, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            cyc("random", $urandom_range(3) == 0, $urandom_range(7) == 0,
                $urandom_range(39) == 0, $urandom_range(11) == 0, $urandom_range(1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
